// File: rtl/intr_pkg.sv
// Shared constants for the machine interrupt source: interrupt codes,
// register word offsets, CTRL/PEND bit positions and the arbitration rule.
package intr_pkg;

  localparam logic [3:0] INTR_NONE  = 4'd0;
  localparam logic [3:0] INTR_TIMER = 4'd1;
  localparam logic [3:0] INTR_EXT   = 4'd2;

  // Word index taken from addr[4:2]
  localparam logic [2:0] REG_MTIME_LO    = 3'd0;
  localparam logic [2:0] REG_MTIME_HI    = 3'd1;
  localparam logic [2:0] REG_MTIMECMP_LO = 3'd2;
  localparam logic [2:0] REG_MTIMECMP_HI = 3'd3;
  localparam logic [2:0] REG_CTRL        = 3'd4;
  localparam logic [2:0] REG_PEND        = 3'd5;

  localparam int CTRL_TEN = 0;
  localparam int CTRL_XEN = 1;
  localparam int CTRL_RUN = 2;

  localparam int PEND_TP = 0;
  localparam int PEND_XP = 1;

  // External interrupts outrank the timer.
  function automatic logic [3:0] arbitrate(input logic tp, input logic xp,
                                           input logic ten, input logic xen);
    if (xp && xen)      return INTR_EXT;
    else if (tp && ten) return INTR_TIMER;
    else                return INTR_NONE;
  endfunction

endpackage

// File: rtl/intr_source_ctrl_sync_edge_det.sv
// Multi-flop synchronizer for an asynchronous level, followed by a
// one-cycle rising-edge pulse on the synchronized signal.
module sync_edge_det #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic level,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], level};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign rise = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/intr_source_ctrl.sv
// Machine interrupt source: memory-mapped 64-bit mtime/mtimecmp timer,
// synchronized external request, pending latches and a held interrupt code.
module intr_source_ctrl
  import intr_pkg::*;
#(
  parameter int PRESCALE    = 1,
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  addr,
  input  logic [31:0] wdata,
  input  logic        we,
  input  logic        re,
  output logic [31:0] rdata,
  input  logic        ext_irq,
  input  logic        intr_ack,
  output logic [3:0]  interrupt
);

  localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  logic [63:0]   mtime_q, mtime_d;
  logic [63:0]   mtimecmp_q;
  logic [2:0]    ctrl_q, ctrl_d;
  logic [CW-1:0] pre_cnt_q;
  logic          tp_q, tp_d, xp_q, xp_d;
  logic          cmp, cmp_q;
  logic [3:0]    intr_q;
  logic          tick;
  logic          set_tp, set_xp, clr_tp, clr_xp;
  logic [2:0]    sel;
  logic          wr_mtime_lo, wr_mtime_hi, wr_cmp_lo, wr_cmp_hi, wr_ctrl, wr_pend;
  logic          unused_addr_bits;

  assign unused_addr_bits = ^addr[1:0];

  // Bus: a strobe is a single-cycle request that always completes; there is
  // no wait state. Reads are combinational, writes land on the next edge.
  assign sel         = addr[4:2];
  assign wr_mtime_lo = we && (sel == REG_MTIME_LO);
  assign wr_mtime_hi = we && (sel == REG_MTIME_HI);
  assign wr_cmp_lo   = we && (sel == REG_MTIMECMP_LO);
  assign wr_cmp_hi   = we && (sel == REG_MTIMECMP_HI);
  assign wr_ctrl     = we && (sel == REG_CTRL);
  assign wr_pend     = we && (sel == REG_PEND);

  assign tick = ctrl_q[CTRL_RUN] && (pre_cnt_q == CW'(PRESCALE - 1));

  // A bus write to one half wins over the increment; the other half holds.
  always_comb begin
    mtime_d = mtime_q;
    if (tick)        mtime_d = mtime_q + 64'd1;
    if (wr_mtime_lo) mtime_d = {mtime_q[63:32], wdata};
    if (wr_mtime_hi) mtime_d = {wdata, mtime_q[31:0]};
  end

  sync_edge_det #(.SYNC_STAGES(SYNC_STAGES)) u_ext_sync (
    .clk   (clk),
    .rst   (rst),
    .level (ext_irq),
    .rise  (set_xp)
  );

  assign cmp    = (mtime_q >= mtimecmp_q);
  assign set_tp = cmp & ~cmp_q;

  assign clr_tp = (wr_pend && wdata[PEND_TP]) || (intr_ack && (intr_q == INTR_TIMER));
  assign clr_xp = (wr_pend && wdata[PEND_XP]) || (intr_ack && (intr_q == INTR_EXT));

  // A new event in the same cycle as a clear keeps the bit set.
  assign tp_d   = set_tp | (tp_q & ~clr_tp);
  assign xp_d   = set_xp | (xp_q & ~clr_xp);
  assign ctrl_d = wr_ctrl ? wdata[2:0] : ctrl_q;

  // Arbitrate on already-latched pending bits (one cycle of latency for a new
  // event) but let clears and enable changes show on the very next edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      mtime_q    <= '0;
      mtimecmp_q <= 64'hFFFF_FFFF_FFFF_FFFF;
      ctrl_q     <= '0;
      pre_cnt_q  <= '0;
      tp_q       <= 1'b0;
      xp_q       <= 1'b0;
      cmp_q      <= 1'b0;
      intr_q     <= INTR_NONE;
    end else begin
      mtime_q <= mtime_d;
      if (wr_cmp_lo) mtimecmp_q[31:0]  <= wdata;
      if (wr_cmp_hi) mtimecmp_q[63:32] <= wdata;
      ctrl_q <= ctrl_d;
      if (ctrl_q[CTRL_RUN]) pre_cnt_q <= tick ? '0 : pre_cnt_q + CW'(1);
      tp_q   <= tp_d;
      xp_q   <= xp_d;
      cmp_q  <= cmp;
      intr_q <= arbitrate(tp_q & tp_d, xp_q & xp_d, ctrl_d[CTRL_TEN], ctrl_d[CTRL_XEN]);
    end
  end

  always_comb begin
    rdata = '0;
    if (re) begin
      case (sel)
        REG_MTIME_LO:    rdata = mtime_q[31:0];
        REG_MTIME_HI:    rdata = mtime_q[63:32];
        REG_MTIMECMP_LO: rdata = mtimecmp_q[31:0];
        REG_MTIMECMP_HI: rdata = mtimecmp_q[63:32];
        REG_CTRL:        rdata = {29'd0, ctrl_q};
        REG_PEND:        rdata = {30'd0, xp_q, tp_q};
        default:         rdata = '0;
      endcase
    end
  end

  assign interrupt = intr_q;

endmodule

// File: tb/tb_intr_source_ctrl.sv
// Directed bench for intr_source_ctrl: a vector table for register map and
// masking, plus hand-timed sequences for timer, external, priority and races.
module tb_intr_source_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  addr;
  logic [31:0] wdata;
  logic        we;
  logic        re;
  logic [31:0] rdata;
  logic        ext_irq;
  logic        intr_ack;
  logic [3:0]  interrupt;

  int total = 0;
  int bad   = 0;

  localparam logic [4:0] A_MTIME_LO = 5'h00;
  localparam logic [4:0] A_MTIME_HI = 5'h04;
  localparam logic [4:0] A_CMP_LO   = 5'h08;
  localparam logic [4:0] A_CMP_HI   = 5'h0C;
  localparam logic [4:0] A_CTRL     = 5'h10;
  localparam logic [4:0] A_PEND     = 5'h14;

  typedef struct {
    logic        we;
    logic        re;
    logic [4:0]  addr;
    logic [31:0] wdata;
    logic        ack;
    logic        chk_rd;
    logic [31:0] exp_rd;
    logic [3:0]  exp_intr;
  } vec_t;

  vec_t       vecs[$];
  logic [3:0] exp_q[$];

  intr_source_ctrl #(.PRESCALE(1), .SYNC_STAGES(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .addr      (addr),
    .wdata     (wdata),
    .we        (we),
    .re        (re),
    .rdata     (rdata),
    .ext_irq   (ext_irq),
    .intr_ack  (intr_ack),
    .interrupt (interrupt)
  );

  // Clock and reset
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_bus();
    we = 1'b0; re = 1'b0; addr = '0; wdata = '0; intr_ack = 1'b0;
  endtask

  task automatic do_reset();
    idle_bus();
    ext_irq = 1'b0;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Driver tasks
  task automatic bus_write(input logic [4:0] a, input logic [31:0] d);
    we = 1'b1; addr = a; wdata = d;
    tick();
    we = 1'b0; addr = '0; wdata = '0;
  endtask

  task automatic bus_read(input logic [4:0] a, output logic [31:0] d);
    re = 1'b1; addr = a;
    #1;
    d = rdata;
    re = 1'b0; addr = '0;
  endtask

  task automatic ack_cycle();
    intr_ack = 1'b1;
    tick();
    intr_ack = 1'b0;
  endtask

  // Scoreboard checks
  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_intr(input string name, input logic [3:0] exp);
    check32(name, {28'd0, interrupt}, {28'd0, exp});
  endtask

  task automatic check_reg(input string name, input logic [4:0] a, input logic [31:0] exp);
    logic [31:0] d;
    bus_read(a, d);
    check32(name, d, exp);
  endtask

  task automatic add_vec(input logic w, input logic r, input logic [4:0] a,
                         input logic [31:0] d, input logic k, input logic c,
                         input logic [31:0] er, input logic [3:0] ei);
    vec_t v;
    v.we = w; v.re = r; v.addr = a; v.wdata = d; v.ack = k;
    v.chk_rd = c; v.exp_rd = er; v.exp_intr = ei;
    vecs.push_back(v);
  endtask

  initial begin
    logic [3:0] e;
    do_reset();

    // Reset state
    check_intr("reset_intr", 4'd0);
    check32("reset_rdata_idle", rdata, 32'd0);

    // Register map, masking and W1C, applied one vector per cycle.
    //        we   re   addr        wdata          ack  chk  exp_rd         intr
    add_vec(0, 1, A_MTIME_LO, 32'd0,          0, 1, 32'd0,          4'd0);
    add_vec(0, 1, A_CMP_LO,   32'd0,          0, 1, 32'hFFFF_FFFF,  4'd0);
    add_vec(0, 1, A_CMP_HI,   32'd0,          0, 1, 32'hFFFF_FFFF,  4'd0);
    add_vec(0, 1, A_CTRL,     32'd0,          0, 1, 32'd0,          4'd0);
    add_vec(0, 1, A_PEND,     32'd0,          0, 1, 32'd0,          4'd0);
    add_vec(1, 1, 5'h1C,      32'hFFFF_FFFF,  0, 1, 32'd0,          4'd0);
    add_vec(1, 0, A_CMP_HI,   32'd0,          0, 0, 32'd0,          4'd0);
    add_vec(1, 0, A_CMP_LO,   32'd0,          0, 0, 32'd0,          4'd0);
    add_vec(0, 1, A_PEND,     32'd0,          0, 1, 32'd0,          4'd0);
    add_vec(0, 1, A_PEND,     32'd0,          0, 1, 32'd1,          4'd0);
    add_vec(0, 1, A_CTRL,     32'd0,          0, 1, 32'd0,          4'd0);
    add_vec(1, 0, A_CTRL,     32'd1,          0, 0, 32'd0,          4'd1);
    add_vec(0, 1, A_CTRL,     32'd0,          0, 1, 32'd1,          4'd1);
    add_vec(1, 0, A_CTRL,     32'd0,          0, 0, 32'd0,          4'd0);
    add_vec(0, 1, A_PEND,     32'd0,          0, 1, 32'd1,          4'd0);
    add_vec(1, 0, A_CTRL,     32'd1,          0, 0, 32'd0,          4'd1);
    add_vec(1, 0, A_PEND,     32'd1,          0, 0, 32'd0,          4'd0);
    add_vec(0, 1, A_PEND,     32'd0,          1, 1, 32'd0,          4'd0);
    add_vec(0, 1, A_MTIME_LO, 32'd0,          0, 1, 32'd0,          4'd0);
    add_vec(1, 0, A_MTIME_LO, 32'h0000_1234,  0, 0, 32'd0,          4'd0);
    add_vec(0, 1, A_MTIME_LO, 32'd0,          0, 1, 32'h0000_1234,  4'd0);
    add_vec(0, 1, A_MTIME_HI, 32'd0,          0, 1, 32'd0,          4'd0);
    add_vec(0, 1, 5'h1C,      32'd0,          0, 1, 32'd0,          4'd0);

    for (int i = 0; i < vecs.size(); i++) begin
      we = vecs[i].we; re = vecs[i].re; addr = vecs[i].addr;
      wdata = vecs[i].wdata; intr_ack = vecs[i].ack;
      exp_q.push_back(vecs[i].exp_intr);
      #1;
      if (vecs[i].chk_rd) check32($sformatf("vec%0d_rdata", i), rdata, vecs[i].exp_rd);
      tick();
      idle_bus();
      e = exp_q.pop_front();
      check_intr($sformatf("vec%0d_intr", i), e);
    end

    // Timer match at mtime == 20
    do_reset();
    bus_write(A_CMP_HI, 32'd0);
    bus_write(A_CMP_LO, 32'd20);
    bus_write(A_CTRL, 32'h5);
    for (int i = 1; i <= 21; i++) begin
      tick();
      check_intr($sformatf("timer_wait%0d", i), 4'd0);
      if (i == 20) check_reg("timer_mtime20", A_MTIME_LO, 32'd20);
      if (i == 21) check_reg("timer_tp_set", A_PEND, 32'd1);
    end
    tick();
    check_intr("timer_intr", 4'd1);
    for (int i = 0; i < 3; i++) begin
      tick();
      check_intr($sformatf("timer_hold%0d", i), 4'd1);
    end
    ack_cycle();
    check_intr("timer_ack", 4'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check_intr($sformatf("timer_no_rearm%0d", i), 4'd0);
    end
    check_reg("timer_pend_clear", A_PEND, 32'd0);

    // External sync and edge detection
    do_reset();
    bus_write(A_CTRL, 32'h2);
    ext_irq = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      tick();
      if (i < 3) check_reg($sformatf("ext_pend_c%0d", i), A_PEND, 32'd0);
      if (i == 3) check_reg("ext_pend_c3", A_PEND, 32'd2);
      check_intr($sformatf("ext_intr_c%0d", i), (i == 4) ? 4'd2 : 4'd0);
    end
    tick();
    check_intr("ext_hold", 4'd2);
    ack_cycle();
    check_intr("ext_ack", 4'd0);
    for (int i = 0; i < 4; i++) begin
      tick();
      check_intr($sformatf("ext_level_no_retrig%0d", i), 4'd0);
    end
    check_reg("ext_pend_after", A_PEND, 32'd0);
    ext_irq = 1'b0;

    // Priority: TP and XP latched on the same edge
    do_reset();
    bus_write(A_CTRL, 32'h7);
    ext_irq = 1'b1;
    bus_write(A_CMP_HI, 32'd0);
    bus_write(A_CMP_LO, 32'd0);
    tick();
    check_reg("prio_pend_both", A_PEND, 32'd3);
    check_intr("prio_pre", 4'd0);
    tick();
    check_intr("prio_ext_first", 4'd2);
    check_reg("prio_pend_3", A_PEND, 32'd3);
    ack_cycle();
    check_intr("prio_timer_next", 4'd1);
    check_reg("prio_pend_1", A_PEND, 32'd1);
    ack_cycle();
    check_intr("prio_none", 4'd0);
    check_reg("prio_pend_0", A_PEND, 32'd0);
    tick();
    check_intr("prio_stays_none", 4'd0);
    ext_irq = 1'b0;

    // Ack of code 2 in the same cycle a new synchronized edge arrives
    do_reset();
    bus_write(A_CTRL, 32'h2);
    ext_irq = 1'b1;
    tick();
    ext_irq = 1'b0;
    tick();
    ext_irq = 1'b1;
    tick();
    check_reg("race_pend_first", A_PEND, 32'd2);
    tick();
    check_intr("race_intr_first", 4'd2);
    ack_cycle();
    check_intr("race_intr_kept", 4'd2);
    check_reg("race_pend_kept", A_PEND, 32'd2);
    ack_cycle();
    check_intr("race_second_ack", 4'd0);
    check_reg("race_pend_clear", A_PEND, 32'd0);
    ext_irq = 1'b0;

    // mtime wrap and write-over-increment priority
    do_reset();
    bus_write(A_CTRL, 32'h4);
    bus_write(A_MTIME_HI, 32'hFFFF_FFFF);
    bus_write(A_MTIME_LO, 32'hFFFF_FFFE);
    check_reg("wrap_lo_fe", A_MTIME_LO, 32'hFFFF_FFFE);
    check_reg("wrap_hi_ff", A_MTIME_HI, 32'hFFFF_FFFF);
    tick();
    check_reg("wrap_lo_ff", A_MTIME_LO, 32'hFFFF_FFFF);
    tick();
    check_reg("wrap_lo_0", A_MTIME_LO, 32'd0);
    check_reg("wrap_hi_0", A_MTIME_HI, 32'd0);
    tick();
    check_reg("wrap_lo_1", A_MTIME_LO, 32'd1);
    bus_write(A_MTIME_LO, 32'h100);
    check_reg("wprio_lo", A_MTIME_LO, 32'h100);
    check_reg("wprio_hi", A_MTIME_HI, 32'd0);
    tick();
    check_reg("wprio_next", A_MTIME_LO, 32'h101);
    check_intr("wrap_masked", 4'd0);

    // Reset while an interrupt is presented
    do_reset();
    bus_write(A_CTRL, 32'h2);
    ext_irq = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    check_intr("midrst_pre", 4'd2);
    rst = 1'b1;
    tick();
    check_intr("midrst_intr", 4'd0);
    rst = 1'b0;
    check_reg("midrst_pend", A_PEND, 32'd0);
    check_reg("midrst_ctrl", A_CTRL, 32'd0);
    tick();
    check_intr("midrst_after", 4'd0);
    ext_irq = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
